mem_port_master: RTL and testbench
==================================

MEM_PORT_MASTER -- requirements
Module: mem_port_master

Interface
REQ-001 SHALL have parameter D_WIDTH, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter A_WIDTH, default 12, word address width.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready (a "fire").
REQ-007 SHALL have port req_wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  A_WIDTH  word address.
REQ-009 SHALL have port req_wdata  input  D_WIDTH  write data.
REQ-010 SHALL have port req_strb  input  D_WIDTH/8  byte enables for writes.
REQ-011 SHALL have port resp_valid  output  1  read data available.
REQ-012 SHALL have port resp_ready  input  1  consumer takes response when resp_valid && resp_ready.
REQ-013 SHALL have port resp_rdata  output  D_WIDTH  read data.
REQ-014 SHALL have ports mem_addr (output, A_WIDTH), mem_wdata (output, D_WIDTH), mem_wr (output, 1) and mem_rdata (input, D_WIDTH), which drive one port of a 1-cycle-latency synchronous RAM with no byte enables whose read data is undefined after a write.

Function
REQ-015 SHALL drive mem_addr, mem_wdata and mem_wr combinationally from the firing request in the fire cycle; mem_wr SHALL be 0 in every non-write cycle.
REQ-016 SHALL be posted for writes: no response is generated.
REQ-017 SHALL, for a read fired in cycle N, capture mem_rdata in cycle N+1 only; mem_rdata in any other cycle SHALL be ignored.
REQ-018 SHALL hold a 2-entry in-order response FIFO and a read_pending flag.
REQ-019 SHALL, when the FIFO is empty in cycle N+1, bypass mem_rdata to resp_rdata with resp_valid=1 (1-cycle latency); if the response is not taken, it SHALL be pushed into the FIFO.
REQ-020 SHALL deassert req_ready for reads and writes while fifo_count + read_pending >= 2, so that no response is ever dropped.
REQ-021 SHALL sustain one read per cycle while resp_ready=1.
REQ-022 SHALL hold resp_valid and resp_rdata stable while resp_valid && !resp_ready.
REQ-023 SHALL return responses in request order.

Reset
REQ-024 SHALL, while rst=1, force req_ready=0, resp_valid=0, mem_wr=0, mem_addr=0 and mem_wdata=0.
REQ-025 SHALL, on reset, clear the FIFO and read_pending and return the FSM to IDLE; a read in flight SHALL be discarded and a partial write in progress SHALL NOT write memory.
REQ-026 SHALL assert req_ready no earlier than the first cycle after rst falls.

Configuration
REQ-027 SHALL, with macro MEM_PORT_BYTE_EN_EN defined, implement byte writes by read-modify-write using FSM states IDLE -> RMW_RD -> RMW_WR -> IDLE.
REQ-028 SHALL, with the macro defined, perform a write fire with all strb bits set in one cycle, and accept a write fire with strb=0 without any memory access.
REQ-029 SHALL, with the macro defined, handle a partial-strb write fired in cycle N as follows: N issues a memory read and the FSM enters RMW_RD; in N+1, mem_wr=1 with mem_wdata = per-byte merge of req_wdata (strb=1) and mem_rdata (strb=0); address, data and strb are latched at N.
REQ-030 SHALL, with the macro defined, keep req_ready=0 in RMW_RD and RMW_WR, and SHALL NOT push RMW read data to the response path.
REQ-031 SHALL, without the macro, ignore req_strb, perform every write as a full-word write, and omit the FSM.

Structure
REQ-032 SHALL take the FSM state encoding, the FIFO depth constant (2) and the strb-merge function from shared package mem_port_pkg.
REQ-033 SHALL implement the response FIFO as sub-module resp_fifo (2 entries, push/pop/count, simultaneous push and pop allowed when full).

Verification
REQ-034 SHALL be verified by: read of addr 0x010 holding 0xDEADBEEF with resp_ready=1 -> resp_valid at N+1, rdata 0xDEADBEEF.
REQ-035 SHALL be verified by: reads of 0x1, 0x2 and 0x3 back-to-back with resp_ready=0 -> req_ready drops after 2 fires; raising resp_ready returns the first two in order, then the third is accepted.
REQ-036 SHALL be verified by: write 0x12345678 to 0x020, then read -> no response for the write; read returns 0x12345678; mem_rdata garbage during the write cycle is never captured.
REQ-037 SHALL be verified by: with the macro, memory 0xAABBCCDD and write 0x11223344 with strb=4'b0101 -> mem_wr at N+1 with 0xAA22CC44; req_ready=0 for 2 cycles.
REQ-038 SHALL be verified by: with the macro, rst asserted in RMW_RD -> no mem_wr follows, memory unchanged, resp_valid=0.
REQ-039 SHALL be verified by: without the macro, write 0x11223344 with strb=4'b0001 -> memory becomes 0x11223344 in a single cycle.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and helpers for mem_port_master: FSM encoding, response FIFO depth, byte merge.
package mem_port_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRmwRd = 2'd1,
      StRmwWr = 2'd2
   } state_e;

   localparam int unsigned FifoDepth = 2;
   localparam int unsigned CountW    = $clog2(FifoDepth + 1);

   // Picks the new byte where its strobe is set, otherwise keeps the old memory byte.
   function automatic logic [7:0] merge_byte(input logic [7:0] new_byte,
                                             input logic [7:0] old_byte,
                                             input logic       en);
      return en ? new_byte : old_byte;
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// Two-entry in-order response FIFO; push and pop may happen together, also when full.
module resp_fifo
   import mem_port_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic [WIDTH-1:0]  wdata,
   output logic [WIDTH-1:0]  rdata,
   output logic [CountW-1:0] count
);

   logic [WIDTH-1:0]  data_q [FifoDepth];
   logic              wr_ptr_q, rd_ptr_q;
   logic [CountW-1:0] count_q;
   logic              do_push, do_pop;

   assign do_pop  = pop && (count_q != '0);
   assign do_push = push && ((32'(count_q) < FifoDepth) || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) data_q[wr_ptr_q] <= wdata;
   end

   assign rdata = data_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/mem_port_master.sv
// Request/response front end for a 1-cycle synchronous RAM port with posted writes.
// Define MEM_PORT_BYTE_EN_EN to enable byte writes via read-modify-write.
module mem_port_master
   import mem_port_pkg::*;
#(
   parameter int unsigned D_WIDTH = 32,
   parameter int unsigned A_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wr,
   input  logic [A_WIDTH-1:0]   req_addr,
   input  logic [D_WIDTH-1:0]   req_wdata,
   input  logic [D_WIDTH/8-1:0] req_strb,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [D_WIDTH-1:0]   resp_rdata,
   output logic [A_WIDTH-1:0]   mem_addr,
   output logic [D_WIDTH-1:0]   mem_wdata,
   output logic                 mem_wr,
   input  logic [D_WIDTH-1:0]   mem_rdata
);

   localparam int unsigned NBytes = D_WIDTH / 8;

   logic               fire, rd_fire, wr_fire, idle;
   logic               read_pending_q;
   logic [CountW-1:0]  fifo_count;
   logic [CountW:0]    inflight;
   logic [D_WIDTH-1:0] fifo_rdata;
   logic               fifo_empty, push, pop;
   logic               mem_wr_c;
   logic [A_WIDTH-1:0] mem_addr_c;
   logic [D_WIDTH-1:0] mem_wdata_c;

   assign fire    = req_valid && req_ready;
   assign rd_fire = fire && !req_wr;
   assign wr_fire = fire && req_wr;

   // Each queued or in-flight read owns a FIFO slot, so a response can never be dropped.
   assign inflight  = {1'b0, fifo_count} + (CountW + 1)'(read_pending_q);
   assign req_ready = !rst && idle && (32'(inflight) < FifoDepth);

   always_ff @(posedge clk) begin
      if (rst) read_pending_q <= 1'b0;
      else     read_pending_q <= rd_fire;
   end

`ifdef MEM_PORT_BYTE_EN_EN
   state_e             state_q, state_d;
   logic [A_WIDTH-1:0] addr_q;
   logic [D_WIDTH-1:0] wdata_q;
   logic [NBytes-1:0]  strb_q;
   logic [D_WIDTH-1:0] merged;

   assign idle = (state_q == StIdle);

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         strb_q  <= req_strb;
      end
   end

   always_comb begin
      merged = '0;
      for (int i = 0; i < NBytes; i++) begin
         merged[8*i +: 8] = merge_byte(wdata_q[8*i +: 8], mem_rdata[8*i +: 8], strb_q[i]);
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_wr_c    = 1'b0;
      mem_addr_c  = '0;
      mem_wdata_c = '0;
      case (state_q)
         StIdle: begin
            if (rd_fire) begin
               mem_addr_c = req_addr;
            end else if (wr_fire) begin
               if (&req_strb) begin
                  mem_wr_c    = 1'b1;
                  mem_addr_c  = req_addr;
                  mem_wdata_c = req_wdata;
               end else if (|req_strb) begin
                  mem_addr_c = req_addr;
                  state_d    = StRmwRd;
               end
            end
         end
         StRmwRd: begin
            mem_wr_c    = 1'b1;
            mem_addr_c  = addr_q;
            mem_wdata_c = merged;
            state_d     = StRmwWr;
         end
         // RAM read data is undefined right after a write; hold off new requests one cycle.
         StRmwWr: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end
`else
   logic unused_strb;

   assign unused_strb = ^req_strb;
   assign idle        = 1'b1;

   always_comb begin
      mem_wr_c    = wr_fire;
      mem_addr_c  = fire ? req_addr : '0;
      mem_wdata_c = wr_fire ? req_wdata : '0;
   end
`endif

   assign mem_wr    = mem_wr_c && !rst;
   assign mem_addr  = rst ? '0 : mem_addr_c;
   assign mem_wdata = rst ? '0 : mem_wdata_c;

   // Bypass RAM data straight out when nothing is queued ahead; otherwise queue it.
   assign fifo_empty = (fifo_count == '0);
   assign pop        = !rst && !fifo_empty && resp_ready;
   assign push       = !rst && read_pending_q && !(fifo_empty && resp_ready);
   assign resp_valid = !rst && (!fifo_empty || read_pending_q);
   assign resp_rdata = !fifo_empty ? fifo_rdata : (read_pending_q ? mem_rdata : '0);

   resp_fifo #(
      .WIDTH (D_WIDTH)
   ) u_resp_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (mem_rdata),
      .rdata (fifo_rdata),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_mem_port_master.sv
// Directed self-checking bench for mem_port_master with a behavioural 1-cycle RAM.
module tb_mem_port_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wr;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_strb;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_rdata;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wr;
   logic [31:0] mem_rdata;

   logic [31:0] ram [0:4095];

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   // RAM model: read data is garbage in the cycle after a write.
   always @(posedge clk) begin
      if (mem_wr) begin
         ram[mem_addr] <= mem_wdata;
         mem_rdata     <= 32'hBAD0_0BAD;
      end else begin
         mem_rdata <= ram[mem_addr];
      end
   end

   mem_port_master #(
      .D_WIDTH (32),
      .A_WIDTH (12)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_strb   (req_strb),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wr     (mem_wr),
      .mem_rdata  (mem_rdata)
   );

   task automatic drive_req(input logic v, input logic wr, input logic [11:0] a,
                            input logic [31:0] d, input logic [3:0] s);
      req_valid = v;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      req_strb  = s;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_req(1'b1, 1'b1, 12'h123, 32'hFFFF_FFFF, 4'hF);
      #1;
      total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready: got %b want 0", req_ready); else passed++;
      total++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", resp_valid); else passed++;
      total++; if (mem_wr !== 1'b0) $display("FAIL rst_mem_wr: got %b want 0", mem_wr); else passed++;
      total++; if (mem_addr !== 12'h000) $display("FAIL rst_mem_addr: got %h want 000", mem_addr); else passed++;
      total++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else passed++;
      @(negedge clk);
      rst = 1'b0;
      drive_req(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready: got %b want 1", req_ready); else passed++;
      total++; if (resp_valid !== 1'b0) $display("FAIL post_rst_resp: got %b want 0", resp_valid); else passed++;
   endtask

   task automatic test_single_read();
      @(negedge clk);
      resp_ready = 1'b1;
      drive_req(1'b1, 1'b0, 12'h010, 32'h0, 4'h0);
      #1;
      total++; if (mem_addr !== 12'h010) $display("FAIL rd_mem_addr: got %h want 010", mem_addr); else passed++;
      total++; if (mem_wr !== 1'b0) $display("FAIL rd_mem_wr: got %b want 0", mem_wr); else passed++;
      @(negedge clk);
      drive_req(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
      #1;
      total++; if (resp_valid !== 1'b1) $display("FAIL rd_resp_valid: got %b want 1", resp_valid); else passed++;
      total++; if (resp_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata: got %h want deadbeef", resp_rdata); else passed++;
      @(negedge clk);
      #1;
      total++; if (resp_valid !== 1'b0) $display("FAIL rd_resp_done: got %b want 0", resp_valid); else passed++;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      resp_ready = 1'b0;
      drive_req(1'b1, 1'b0, 12'h001, 32'h0, 4'h0);
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL bp_ready1: got %b want 1", req_ready); else passed++;
      @(negedge clk);
      drive_req(1'b1, 1'b0, 12'h002, 32'h0, 4'h0);
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL bp_ready2: got %b want 1", req_ready); else passed++;
      @(negedge clk);
      drive_req(1'b1, 1'b0, 12'h003, 32'h0, 4'h0);
      #1;
      total++; if (req_ready !== 1'b0) $display("FAIL bp_ready3: got %b want 0", req_ready); else passed++;
      total++; if (resp_rdata !== 32'h1111_0001) $display("FAIL bp_hold_a: got %h want 11110001", resp_rdata); else passed++;
      @(negedge clk);
      #1;
      total++; if (req_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", req_ready); else passed++;
      total++; if (resp_valid !== 1'b1) $display("FAIL bp_full_valid: got %b want 1", resp_valid); else passed++;
      total++; if (resp_rdata !== 32'h1111_0001) $display("FAIL bp_hold_b: got %h want 11110001", resp_rdata); else passed++;
      @(negedge clk);
      resp_ready = 1'b1;
      #1;
      total++; if (req_ready !== 1'b0) $display("FAIL bp_pop1_ready: got %b want 0", req_ready); else passed++;
      total++; if (resp_rdata !== 32'h1111_0001) $display("FAIL bp_first: got %h want 11110001", resp_rdata); else passed++;
      @(negedge clk);
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL bp_third_accept: got %b want 1", req_ready); else passed++;
      total++; if (resp_rdata !== 32'h2222_0002) $display("FAIL bp_second: got %h want 22220002", resp_rdata); else passed++;
      @(negedge clk);
      drive_req(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
      #1;
      total++; if (resp_valid !== 1'b1) $display("FAIL bp_third_valid: got %b want 1", resp_valid); else passed++;
      total++; if (resp_rdata !== 32'h3333_0003) $display("FAIL bp_third: got %h want 33330003", resp_rdata); else passed++;
      @(negedge clk);
      #1;
      total++; if (resp_valid !== 1'b0) $display("FAIL bp_drained: got %b want 0", resp_valid); else passed++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_data [3];
      exp_data[0] = 32'h4444_0004;
      exp_data[1] = 32'h5555_0005;
      exp_data[2] = 32'h6666_0006;
      resp_ready  = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 3) drive_req(1'b1, 1'b0, 12'(4 + i), 32'h0, 4'h0);
         else       drive_req(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
         #1;
         if (i < 3) begin
            total++; if (req_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, req_ready); else passed++;
         end
         if (i > 0) begin
            total++; if (resp_valid !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b want 1", i, resp_valid); else passed++;
            total++; if (resp_rdata !== exp_data[i-1]) $display("FAIL b2b_rdata[%0d]: got %h want %h", i, resp_rdata, exp_data[i-1]); else passed++;
         end
      end
   endtask

   task automatic test_write_read();
      resp_ready = 1'b1;
      @(negedge clk);
      drive_req(1'b1, 1'b1, 12'h020, 32'h1234_5678, 4'hF);
      #1;
      total++; if (mem_wr !== 1'b1) $display("FAIL wr_mem_wr: got %b want 1", mem_wr); else passed++;
      total++; if (mem_addr !== 12'h020) $display("FAIL wr_mem_addr: got %h want 020", mem_addr); else passed++;
      total++; if (mem_wdata !== 32'h1234_5678) $display("FAIL wr_mem_wdata: got %h want 12345678", mem_wdata); else passed++;
      @(negedge clk);
      drive_req(1'b1, 1'b0, 12'h020, 32'h0, 4'h0);
      #1;
      total++; if (resp_valid !== 1'b0) $display("FAIL wr_no_resp: got %b want 0", resp_valid); else passed++;
      total++; if (mem_wr !== 1'b0) $display("FAIL wr_rd_mem_wr: got %b want 0", mem_wr); else passed++;
      @(negedge clk);
      drive_req(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
      #1;
      total++; if (resp_valid !== 1'b1) $display("FAIL wr_rd_valid: got %b want 1", resp_valid); else passed++;
      total++; if (resp_rdata !== 32'h1234_5678) $display("FAIL wr_rd_data: got %h want 12345678", resp_rdata); else passed++;
      @(negedge clk);
      #1;
      total++; if (resp_valid !== 1'b0) $display("FAIL wr_rd_done: got %b want 0", resp_valid); else passed++;
   endtask

   task automatic test_reset_inflight();
      resp_ready = 1'b0;
      @(negedge clk);
      drive_req(1'b1, 1'b0, 12'h001, 32'h0, 4'h0);
      @(negedge clk);
      rst = 1'b1;
      drive_req(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
      #1;
      total++; if (resp_valid !== 1'b0) $display("FAIL rsti_valid: got %b want 0", resp_valid); else passed++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (resp_valid !== 1'b0) $display("FAIL rsti_discard: got %b want 0", resp_valid); else passed++;
      resp_ready = 1'b1;
   endtask

`ifdef MEM_PORT_BYTE_EN_EN
   task automatic test_strb_write();
      @(negedge clk);
      drive_req(1'b1, 1'b1, 12'h030, 32'h1122_3344, 4'b0101);
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL rmw_accept: got %b want 1", req_ready); else passed++;
      total++; if (mem_wr !== 1'b0) $display("FAIL rmw_rd_wr: got %b want 0", mem_wr); else passed++;
      total++; if (mem_addr !== 12'h030) $display("FAIL rmw_rd_addr: got %h want 030", mem_addr); else passed++;
      @(negedge clk);
      drive_req(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
      #1;
      total++; if (mem_wr !== 1'b1) $display("FAIL rmw_wr: got %b want 1", mem_wr); else passed++;
      total++; if (mem_wdata !== 32'hAA22_CC44) $display("FAIL rmw_merge: got %h want aa22cc44", mem_wdata); else passed++;
      total++; if (req_ready !== 1'b0) $display("FAIL rmw_busy1: got %b want 0", req_ready); else passed++;
      total++; if (resp_valid !== 1'b0) $display("FAIL rmw_no_resp: got %b want 0", resp_valid); else passed++;
      @(negedge clk);
      #1;
      total++; if (req_ready !== 1'b0) $display("FAIL rmw_busy2: got %b want 0", req_ready); else passed++;
      total++; if (mem_wr !== 1'b0) $display("FAIL rmw_wr_once: got %b want 0", mem_wr); else passed++;
      @(negedge clk);
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL rmw_ready_back: got %b want 1", req_ready); else passed++;
      total++; if (ram[12'h030] !== 32'hAA22_CC44) $display("FAIL rmw_ram: got %h want aa22cc44", ram[12'h030]); else passed++;
   endtask

   task automatic test_rmw_reset();
      @(negedge clk);
      drive_req(1'b1, 1'b1, 12'h040, 32'h0102_0304, 4'b0011);
      @(negedge clk);
      rst = 1'b1;
      drive_req(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
      #1;
      total++; if (mem_wr !== 1'b0) $display("FAIL rmwrst_wr: got %b want 0", mem_wr); else passed++;
      total++; if (resp_valid !== 1'b0) $display("FAIL rmwrst_resp: got %b want 0", resp_valid); else passed++;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (mem_wr !== 1'b0) $display("FAIL rmwrst_wr_after: got %b want 0", mem_wr); else passed++;
      total++; if (ram[12'h040] !== 32'h5566_7788) $display("FAIL rmwrst_ram: got %h want 55667788", ram[12'h040]); else passed++;
   endtask
`else
   task automatic test_strb_write();
      @(negedge clk);
      drive_req(1'b1, 1'b1, 12'h030, 32'h1122_3344, 4'b0001);
      #1;
      total++; if (mem_wr !== 1'b1) $display("FAIL full_wr: got %b want 1", mem_wr); else passed++;
      total++; if (mem_wdata !== 32'h1122_3344) $display("FAIL full_wdata: got %h want 11223344", mem_wdata); else passed++;
      @(negedge clk);
      drive_req(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
      #1;
      total++; if (ram[12'h030] !== 32'h1122_3344) $display("FAIL full_ram: got %h want 11223344", ram[12'h030]); else passed++;
      total++; if (req_ready !== 1'b1) $display("FAIL full_ready: got %b want 1", req_ready); else passed++;
   endtask
`endif

   initial begin
      rst        = 1'b1;
      resp_ready = 1'b0;
      drive_req(1'b0, 1'b0, 12'h000, 32'h0, 4'h0);
      ram[12'h010] <= 32'hDEAD_BEEF;
      ram[12'h001] <= 32'h1111_0001;
      ram[12'h002] <= 32'h2222_0002;
      ram[12'h003] <= 32'h3333_0003;
      ram[12'h004] <= 32'h4444_0004;
      ram[12'h005] <= 32'h5555_0005;
      ram[12'h006] <= 32'h6666_0006;
      ram[12'h030] <= 32'hAABB_CCDD;
      ram[12'h040] <= 32'h5566_7788;
      repeat (3) @(posedge clk);
      test_reset();
      test_single_read();
      test_backpressure();
      test_back_to_back();
      test_write_read();
      test_reset_inflight();
      test_strb_write();
`ifdef MEM_PORT_BYTE_EN_EN
      test_rmw_reset();
`endif
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
